// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, stall hold buffer and branch redirect
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchsel,
    input  logic [31:0] PCbranch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instruction,
    output logic [31:0] PC_out,
    output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, REDIRECT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] hold_buf;
    logic [31:0] target;
    logic [31:0] branch_tgt;
    logic        branch_lsb_unused;

    assign pc_plus4          = pc + 32'd4;
    assign branch_tgt        = {PCbranch[31:2], 2'b00};
    assign branch_lsb_unused = ^PCbranch[1:0];
    assign imem_addr         = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            pc          <= 32'd0;
            hold_buf    <= 32'd0;
            target      <= 32'd0;
            instruction <= 32'd0;
            PC_out      <= 32'd0;
            if_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (branchsel) begin
                        pc <= branch_tgt;
                    end
                end

                FETCH: begin
                    if (branchsel) begin
                        instruction <= 32'd0;
                        PC_out      <= 32'd0;
                        if_valid    <= 1'b0;
                        hold_buf    <= 32'd0;
                        if (imem_ready) begin
                            pc <= branch_tgt;
                        end else begin
                            // The outstanding response still has to drain at the old address.
                            target <= branch_tgt;
                            state  <= REDIRECT;
                        end
                    end else if (stall) begin
                        if (imem_ready) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        instruction <= imem_rdata;
                        PC_out      <= pc_plus4;
                        if_valid    <= 1'b1;
                        pc          <= pc_plus4;
                    end else begin
                        instruction <= 32'd0;
                        if_valid    <= 1'b0;
                    end
                end

                HOLD: begin
                    if (branchsel) begin
                        instruction <= 32'd0;
                        PC_out      <= 32'd0;
                        if_valid    <= 1'b0;
                        hold_buf    <= 32'd0;
                        pc          <= branch_tgt;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end else if (!stall) begin
                        instruction <= hold_buf;
                        PC_out      <= pc_plus4;
                        if_valid    <= 1'b1;
                        pc          <= pc_plus4;
                        hold_buf    <= 32'd0;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end
                end

                REDIRECT: begin
                    // A new branch while draining replaces the pending target (last wins).
                    if (imem_ready) begin
                        pc    <= branchsel ? branch_tgt : target;
                        state <= FETCH;
                    end else if (branchsel) begin
                        target <= branch_tgt;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic ifid_load;

    always_comb begin
        ifid_load = 1'b0;
        if (!branchsel && !stall) begin
            ifid_load = ((state == FETCH) && imem_ready) || (state == HOLD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (ifid_load) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall && (state != IDLE)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a behavioural model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branchsel;
    logic [31:0] PCbranch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instruction;
    logic [31:0] PC_out;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_stage dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branchsel(branchsel),
        .PCbranch(PCbranch),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .instruction(instruction),
        .PC_out(PC_out),
        .if_valid(if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: started / buffered word pending / redirect pending
    bit          m_started, m_hold, m_redir;
    logic [31:0] m_pc, m_instr, m_pcout, m_buf, m_tgt;
    logic        m_valid;

    function automatic logic m_req();
        return m_started && !m_hold;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_hold = 0; m_redir = 0;
        m_pc = 0; m_instr = 0; m_pcout = 0; m_buf = 0; m_tgt = 0; m_valid = 0;
    endtask

    task automatic m_flush();
        m_instr = 0; m_pcout = 0; m_valid = 0;
    endtask

    task automatic m_load(input logic [31:0] w);
        m_instr = w; m_pcout = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
    endtask

    task automatic model_update();
        logic [31:0] t;
        t = {PCbranch[31:2], 2'b00};
        if (!m_started) begin
            m_started = 1;
            if (branchsel) begin m_pc = t; m_flush(); end
        end else if (m_redir) begin
            if (branchsel) m_tgt = t;
            if (imem_ready) begin m_pc = m_tgt; m_redir = 0; end
        end else if (m_hold) begin
            if (branchsel) begin m_flush(); m_hold = 0; m_pc = t; end
            else if (!stall) begin m_load(m_buf); m_hold = 0; end
        end else begin
            if (branchsel) begin
                m_flush();
                if (imem_ready) m_pc = t;
                else begin m_redir = 1; m_tgt = t; end
            end else if (stall) begin
                if (imem_ready) begin m_hold = 1; m_buf = imem_rdata; end
            end else if (imem_ready) begin
                m_load(imem_rdata);
            end else begin
                m_instr = 0; m_valid = 0;
            end
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] tgt, input logic rdy);
        stall = s; branchsel = b; PCbranch = tgt; imem_ready = rdy; imem_rdata = $urandom;
    endtask

    // Called at a negedge with inputs driven; leaves at the next negedge.
    task automatic step();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
        chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        model_update();
        #1;
        chk("instruction", instruction, m_instr);
        chk("PC_out", PC_out, m_pcout);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        @(negedge clk);
    endtask

    initial begin
        int wcnt;
        logic [31:0] saved_instr, saved_word;

        reset = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        #50;
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_PC_out", PC_out, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;

        // Zero-wait memory: PC_out 4, 8, 12 ... from the second cycle after release
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, m_req());
            step();
            if (k == 1) chk("zw_first_valid", {31'd0, if_valid}, 32'd0);
            else chk("zw_pc_seq", PC_out, 32'(4 * (k - 1)));
        end

        // Two-cycle memory latency: two NOP bubbles between valid instructions
        wcnt = 0;
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 0, m_req() && (wcnt == 2));
            step();
            if (imem_ready) begin
                chk("lat2_valid", {31'd0, if_valid}, 32'd1);
                wcnt = 0;
            end else begin
                chk("lat2_bubble", {31'd0, if_valid}, 32'd0);
                wcnt++;
            end
        end
        while (!m_req() || m_redir) begin
            drive(0, 0, 0, 1);
            step();
        end

        // Stall for three cycles coincident with ready
        saved_instr = instruction;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1);
            if (k == 0) saved_word = imem_rdata;
            step();
            chk("stall_hold", instruction, saved_instr);
        end
        drive(0, 0, 0, 0);
        step();
        chk("stall_release_word", instruction, saved_word);
        chk("stall_release_valid", {31'd0, if_valid}, 32'd1);

        // Branch with stall in the same cycle: flush, aligned target
        drive(1, 1, 32'h0000_0043, 1);
        step();
        chk("br_stall_addr", imem_addr, 32'h0000_0040);
        chk("br_stall_flush", {31'd0, if_valid}, 32'd0);

        // PC wrap from 0xFFFFFFFC
        drive(0, 1, 32'hFFFF_FFFE, 1);
        step();
        chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1);
        step();
        chk("wrap_pc_out", PC_out, 32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Branch while waiting: old response discarded, then fetch at target
        drive(0, 1, 32'h0000_0200, 0);
        step();
        chk("redir_old_addr", imem_addr, 32'h0000_0000);
        drive(0, 0, 0, 0);
        step();
        drive(0, 0, 0, 1);
        step();
        chk("redir_discard", {31'd0, if_valid}, 32'd0);
        chk("redir_target", imem_addr, 32'h0000_0200);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom, $urandom_range(2) != 0);
            step();
        end

        // Asynchronous reset mid-wait, then a late ready that must be ignored
        drive(0, 0, 0, 0);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk("async_instruction", instruction, 32'd0);
        chk("async_PC_out", PC_out, 32'd0);
        chk("async_if_valid", {31'd0, if_valid}, 32'd0);
        chk("async_imem_req", {31'd0, imem_req}, 32'd0);
        chk("async_imem_addr", imem_addr, 32'd0);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        drive(0, 0, 0, 1);
        step();
        chk("late_ready_ignored", {31'd0, if_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, m_req());
            step();
        end
        chk("post_reset_pc_out", PC_out, 32'd20);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'd5);
        chk("stall_cnt", stall_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low (0 = reset); reset takes effect immediately, release is sampled on clk.
REQ-003 SHALL have port: stall  input  1  hazard hold; PC and IF/ID register keep value.
REQ-004 SHALL have port: branchsel  input  1  taken branch/jump redirect.
REQ-005 SHALL have port: PCbranch  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-006 SHALL have port: imem_req  output  1  instruction memory request.
REQ-007 SHALL have port: imem_addr  output  32  fetch address; always equals internal PC.
REQ-008 SHALL have port: imem_rdata  input  32  instruction word; valid when imem_ready=1.
REQ-009 SHALL have port: imem_ready  input  1  response strobe; may be same cycle as imem_req (zero wait) or later.
REQ-010 SHALL have port: instruction  output  32  IF/ID instruction to decode.
REQ-011 SHALL have port: PC_out  output  32  IF/ID PC+4 of held instruction.
REQ-012 SHALL have port: if_valid  output  1  IF/ID holds a real instruction.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, HOLD, REDIRECT.
REQ-014 IDLE: imem_req=0; SHALL go to FETCH on first clock after reset release.
REQ-015 FETCH: imem_req=1, imem_addr stable until imem_ready=1 (memory-side contract).
REQ-016 FETCH, ready=1, stall=0, branchsel=0: SHALL load instruction<=imem_rdata, PC_out<=PC+4, if_valid<=1, PC<=PC+4, stay FETCH; throughput one instruction/cycle at zero wait.
REQ-017 FETCH, ready=0, stall=0, branchsel=0: SHALL load instruction<=0 (NOP), if_valid<=0; PC held.
REQ-018 FETCH, ready=1, stall=1: SHALL capture imem_rdata in a one-entry buffer, hold IF/ID and PC, go HOLD.
REQ-019 HOLD: imem_req=0; while stall=1 SHALL hold; on stall=0 SHALL load IF/ID from buffer, PC<=PC+4, go FETCH.
REQ-020 stall=1 in FETCH with ready=0: IF/ID and PC held, request continues.
REQ-021 branchsel=1 SHALL override stall in every state: IF/ID flushed (instruction=0, PC_out=0, if_valid=0), buffer discarded.
REQ-022 branchsel=1 in FETCH with ready=1, or in IDLE/HOLD: PC<={PCbranch[31:2],2'b00}, go FETCH.
REQ-023 branchsel=1 in FETCH with ready=0: latch target, go REDIRECT; REDIRECT keeps imem_req=1 at old address, discards the response on ready=1, then loads PC from latched target, go FETCH.
REQ-024 branchsel=1 in REDIRECT: SHALL replace latched target (last wins).
REQ-025 PC arithmetic modulo 2^32: PC 0xFFFFFFFC + 4 SHALL wrap to 0x00000000.

Reset
REQ-026 On reset=0 SHALL set PC=0, instruction=0, PC_out=0, if_valid=0, imem_req=0, buffer=0, state=IDLE, counters (if present)=0, regardless of pending request.
REQ-027 Reset mid-request SHALL abandon the request; a late imem_ready after release SHALL be ignored until FETCH is entered.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: SHALL add outputs fetch_cnt (32) counting REQ-016/REQ-019 IF/ID loads, and stall_cnt (32) counting cycles with stall=1 and state!=IDLE; both wrap at 2^32.
REQ-029 FETCH_PERF_CNT_EN undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-030 Zero-wait memory (ready=req), reset released at 100 ns -> PC_out sequence 4,8,12,... one per cycle, if_valid=1 from second cycle after release.
REQ-031 Memory ready 2 cycles after req -> NOP bubble (if_valid=0) 2 cycles between valid instructions, imem_addr stable during wait.
REQ-032 stall=1 for 3 cycles coincident with ready -> IF/ID unchanged 3 cycles, buffered word appears next cycle after stall falls, no instruction lost/duplicated.
REQ-033 branchsel=1, PCbranch=0x00000043, stall=1 same cycle -> flush, next imem_addr=0x00000040.
REQ-034 branchsel=1 while waiting (ready=0) -> old response discarded, next fetch at target; PC start 0xFFFFFFFC (via branch) -> next addr 0x00000000.
REQ-035 reset=0 asserted mid-wait -> all outputs 0 immediately (async); with FETCH_PERF_CNT_EN, fetch_cnt=5 after 5 zero-wait fetches.
